// File: rtl/spi_slave_reg_bridge.sv
// Register-bus master driven by the spi_slave word stream: command word, then write data or read slots.
// Define SPI_REG_BRIDGE_AUTOINC_EN for burst addressing; otherwise every data word targets the command address.
module spi_slave_reg_bridge #(
    parameter int unsigned ADDR_WIDTH = 7,
    parameter logic [7:0]  IDLE_TX    = 8'hFF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic [7:0]            rx_data,
    input  logic                  rx_rdy,
    output logic                  rx_ack,
    input  logic                  frame_end,
    output logic                  frame_end_ack,
    output logic [7:0]            tx_data,
    output logic [ADDR_WIDTH-1:0] reg_addr,
    output logic [7:0]            reg_wdata,
    output logic                  reg_wr,
    output logic                  reg_rd,
    input  logic [7:0]            reg_rdata,
    input  logic                  reg_rvalid,
    output logic                  busy
);

    localparam int unsigned DATA_W  = 8;
    localparam int unsigned GUARD_W = 2;
    localparam logic [GUARD_W-1:0] GUARD_LOAD = GUARD_W'(2);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_WR      = 2'd1,
        S_RD_WAIT = 2'd2,
        S_RD      = 2'd3
    } state_e;

    state_e              state_q, state_d;
    logic [GUARD_W-1:0]  guard_q, guard_d;
    logic [GUARD_W-1:0]  fe_guard_q, fe_guard_d;
    logic                rx_ack_q, rx_ack_d;
    logic                fe_ack_q, fe_ack_d;
    logic                wr_pend_q, wr_pend_d;
    logic                rd_pend_q, rd_pend_d;
    logic                reg_wr_q, reg_wr_d;
    logic                reg_rd_q, reg_rd_d;
    logic [ADDR_WIDTH-1:0] reg_addr_q, reg_addr_d;
    logic [DATA_W-1:0]   reg_wdata_q, reg_wdata_d;
    logic [DATA_W-1:0]   tx_data_q, tx_data_d;
    logic                busy_q, busy_d;
    logic                word_acc;

    assign word_acc = rx_rdy && (guard_q == '0) && en;

    // Next-state and registered-output logic
    always_comb begin
        state_d     = state_q;
        guard_d     = (guard_q != '0) ? guard_q - GUARD_W'(1) : '0;
        fe_guard_d  = (fe_guard_q != '0) ? fe_guard_q - GUARD_W'(1) : '0;
        rx_ack_d    = 1'b0;
        fe_ack_d    = 1'b0;
        wr_pend_d   = 1'b0;
        rd_pend_d   = 1'b0;
        reg_wr_d    = wr_pend_q;
        reg_rd_d    = rd_pend_q;
        reg_addr_d  = reg_addr_q;
        reg_wdata_d = reg_wdata_q;
        tx_data_d   = tx_data_q;

`ifdef SPI_REG_BRIDGE_AUTOINC_EN
        if (reg_wr_q) begin
            reg_addr_d = reg_addr_q + ADDR_WIDTH'(1);
        end
`endif

        if ((state_q == S_RD_WAIT) && reg_rvalid) begin
            tx_data_d = reg_rdata;
            state_d   = S_RD;
        end

        if (word_acc) begin
            rx_ack_d = 1'b1;
            guard_d  = GUARD_LOAD;
            case (state_q)
                S_IDLE: begin
                    reg_addr_d = rx_data[ADDR_WIDTH-1:0];
                    if (rx_data[DATA_W-1]) begin
                        rd_pend_d = 1'b1;
                        state_d   = S_RD_WAIT;
                    end else begin
                        state_d   = S_WR;
                    end
                end
                S_WR: begin
                    reg_wdata_d = rx_data;
                    wr_pend_d   = 1'b1;
                end
                S_RD: begin
`ifdef SPI_REG_BRIDGE_AUTOINC_EN
                    reg_addr_d = reg_addr_q + ADDR_WIDTH'(1);
`endif
                    rd_pend_d  = 1'b1;
                    state_d    = S_RD_WAIT;
                end
                default: ;
            endcase
        end

        // Frame end wins the state but leaves already scheduled strobes alone
        if (frame_end && (fe_guard_q == '0) && en) begin
            fe_ack_d   = 1'b1;
            fe_guard_d = GUARD_LOAD;
            state_d    = S_IDLE;
            tx_data_d  = IDLE_TX;
        end

        if (!en) begin
            state_d   = S_IDLE;
            rx_ack_d  = 1'b0;
            fe_ack_d  = 1'b0;
            wr_pend_d = 1'b0;
            rd_pend_d = 1'b0;
            reg_wr_d  = 1'b0;
            reg_rd_d  = 1'b0;
        end

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            guard_q     <= '0;
            fe_guard_q  <= '0;
            rx_ack_q    <= 1'b0;
            fe_ack_q    <= 1'b0;
            wr_pend_q   <= 1'b0;
            rd_pend_q   <= 1'b0;
            reg_wr_q    <= 1'b0;
            reg_rd_q    <= 1'b0;
            reg_addr_q  <= '0;
            reg_wdata_q <= '0;
            tx_data_q   <= IDLE_TX;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            guard_q     <= guard_d;
            fe_guard_q  <= fe_guard_d;
            rx_ack_q    <= rx_ack_d;
            fe_ack_q    <= fe_ack_d;
            wr_pend_q   <= wr_pend_d;
            rd_pend_q   <= rd_pend_d;
            reg_wr_q    <= reg_wr_d;
            reg_rd_q    <= reg_rd_d;
            reg_addr_q  <= reg_addr_d;
            reg_wdata_q <= reg_wdata_d;
            tx_data_q   <= tx_data_d;
            busy_q      <= busy_d;
        end
    end

    assign rx_ack        = rx_ack_q;
    assign frame_end_ack = fe_ack_q;
    assign tx_data       = tx_data_q;
    assign reg_addr      = reg_addr_q;
    assign reg_wdata     = reg_wdata_q;
    assign reg_wr        = reg_wr_q;
    assign reg_rd        = reg_rd_q;
    assign busy          = busy_q;

endmodule
